// File: rtl/demux_1x8_deser.sv
// -----------------------------------------------------------------------------
// demux_1x8_deser
//
// Receiving end of a time-multiplexed serial link. A remote 8x1 mux steps its
// select through 0..N-1 and places one bit per valid beat on a single wire.
// This block follows with its own slot counter. It collects the beats of a
// frame in a shadow register, then publishes the completed word together with
// a one-cycle valid strobe.
//
// A frame starts with a beat that has sof=1. A sof beat that arrives while a
// frame is only partly collected drops that frame, raises a one-cycle err
// pulse, and starts a new frame from slot 0.
//
// Parameters:
//   N   number of slots and the output word width (power of 2, >= 2)
//   SW  slot counter width, must equal log2(N)
//
// Ports:
//   clk        in   rising-edge clock for all state
//   rst_n      in   asynchronous active-low reset
//   din        in   serial data bit for the current slot
//   din_valid  in   din carries a valid beat this cycle
//   sof        in   start-of-frame, qualified by din_valid
//   s          out  slot index that the next valid beat will fill
//   o          out  last completed word, slot k on o[k]
//   o_valid    out  one-cycle pulse when o has just been updated
//   busy       out  high while a frame is partially collected
//   err        out  one-cycle pulse when a frame is aborted by an early sof
// -----------------------------------------------------------------------------
module demux_1x8_deser #(
    parameter int N  = 8,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din,
    input  logic          din_valid,
    input  logic          sof,
    output logic [SW-1:0] s,
    output logic [N-1:0]  o,
    output logic          o_valid,
    output logic          busy,
    output logic          err
);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [SW-1:0] LAST_SLOT  = SW'(N - 1);
    localparam logic [SW-1:0] FIRST_NEXT = SW'(1);

    state_t          state_q,   state_d;
    logic [SW-1:0]   s_q,       s_d;
    logic [N-1:0]    shadow_q,  shadow_d;
    logic [N-1:0]    o_q,       o_d;
    logic            o_valid_q, o_valid_d;
    logic            err_q,     err_d;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            s_q       <= '0;
            shadow_q  <= '0;
            o_q       <= '0;
            o_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            shadow_q  <= shadow_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
            err_q     <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        shadow_d  = shadow_q;
        o_d       = o_q;
        o_valid_d = 1'b0;
        err_d     = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                IDLE: begin
                    // Beats without sof carry no frame alignment, so drop them.
                    if (sof) begin
                        shadow_d    = '0;
                        shadow_d[0] = din;
                        s_d         = FIRST_NEXT;
                        state_d     = COLLECT;
                    end
                end

                COLLECT: begin
                    if (sof) begin
                        // Resync: this beat is slot 0 of a fresh frame. o is
                        // left alone because the dropped frame never finished.
                        err_d       = 1'b1;
                        shadow_d    = '0;
                        shadow_d[0] = din;
                        s_d         = FIRST_NEXT;
                    end else begin
                        shadow_d[s_q] = din;
                        if (s_q == LAST_SLOT) begin
                            // The final bit bypasses the shadow so that the
                            // word is published on the same edge.
                            o_d       = {din, shadow_q[N-2:0]};
                            o_valid_d = 1'b1;
                            s_d       = '0;
                            state_d   = IDLE;
                        end else begin
                            s_d = s_q + FIRST_NEXT;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign s       = s_q;
    assign o       = o_q;
    assign o_valid = o_valid_q;
    assign err     = err_q;
    assign busy    = (state_q == COLLECT);

endmodule

// File: tb/tb_demux_1x8_deser.sv
module tb_demux_1x8_deser;

    logic       clk;
    logic       rst_n;
    logic       din, din_valid, sof;
    logic [2:0] s;
    logic [7:0] o;
    logic       o_valid, busy, err;

    logic       din4, din_valid4, sof4;
    logic [1:0] s4;
    logic [3:0] o4;
    logic       o_valid4, busy4, err4;

    int unsigned n_checks;
    int unsigned n_fail;

    demux_1x8_deser #(.N(8), .SW(3)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
        .s(s), .o(o), .o_valid(o_valid), .busy(busy), .err(err)
    );

    demux_1x8_deser #(.N(4), .SW(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .din(din4), .din_valid(din_valid4), .sof(sof4),
        .s(s4), .o(o4), .o_valid(o_valid4), .busy(busy4), .err(err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of input to the N=8 instance; returns #1 after the edge.
    task automatic beat(input logic v, input logic sf, input logic d);
        din_valid = v; sof = sf; din = d;
        @(posedge clk); #1;
        din_valid = 1'b0; sof = 1'b0; din = 1'b0;
    endtask

    task automatic beat4(input logic v, input logic sf, input logic d);
        din_valid4 = v; sof4 = sf; din4 = d;
        @(posedge clk); #1;
        din_valid4 = 1'b0; sof4 = 1'b0; din4 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        din = 0; din_valid = 0; sof = 0;
        din4 = 0; din_valid4 = 0; sof4 = 0;
        #3;
        n_checks++;
        if ({s, o, o_valid, busy, err} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_state: got s=%0d o=%h ov=%b busy=%b err=%b expected all 0",
                     s, o, o_valid, busy, err);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({s, o, o_valid, busy, err} !== 14'h0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got s=%0d o=%h ov=%b busy=%b err=%b expected all 0",
                     s, o, o_valid, busy, err);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] w;
        w = 8'hC8;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (s !== 3'(k)) begin
                n_fail++;
                $display("FAIL single_slot_%0d: got s=%0d expected %0d", k, s, k);
            end
            beat(1'b1, k == 0, w[k]);
            if (k < 7) begin
                n_checks++;
                if (o_valid !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_mid_%0d: got ov=%b busy=%b expected ov=0 busy=1",
                             k, o_valid, busy);
                end
            end
        end
        n_checks++;
        if (o !== 8'hC8 || o_valid !== 1'b1 || busy !== 1'b0 || s !== 3'd0) begin
            n_fail++;
            $display("FAIL single_done: got o=%h ov=%b busy=%b s=%0d expected o=c8 ov=1 busy=0 s=0",
                     o, o_valid, busy, s);
        end
        beat(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (o_valid !== 1'b0 || o !== 8'hC8 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse_width: got ov=%b o=%h busy=%b expected ov=0 o=c8 busy=0",
                     o_valid, o, busy);
        end
    endtask

    task automatic test_gaps();
        logic [7:0]  w;
        int unsigned pulses;
        w = 8'hC8;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            beat(1'b1, k == 0, w[k]);
            if (o_valid === 1'b1) pulses++;
            if (k == 2 || k == 5) begin
                for (int g = 0; g < ((k == 2) ? 3 : 1); g++) begin
                    beat(1'b0, 1'b0, 1'b1);
                    if (o_valid === 1'b1) pulses++;
                    n_checks++;
                    if (s !== 3'(k + 1) || busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL gap_hold_%0d_%0d: got s=%0d busy=%b expected s=%0d busy=1",
                                 k, g, s, busy, k + 1);
                    end
                end
            end
        end
        n_checks++;
        if (o !== 8'hC8 || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_done: got o=%h ov=%b expected o=c8 ov=1", o, o_valid);
        end
        beat(1'b0, 1'b0, 1'b0);
        if (o_valid === 1'b1) pulses++;
        n_checks++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL gap_pulse_count: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        int          first_at, second_at;
        int unsigned pulses;
        w = 16'h35C8;
        pulses = 0; first_at = -1; second_at = -1;
        for (int k = 0; k < 16; k++) begin
            beat(1'b1, (k % 8) == 0, w[k]);
            if (o_valid === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    first_at = k;
                    n_checks++;
                    if (o !== 8'hC8) begin
                        n_fail++;
                        $display("FAIL b2b_first_word: got %h expected c8", o);
                    end
                end else begin
                    second_at = k;
                    n_checks++;
                    if (o !== 8'h35) begin
                        n_fail++;
                        $display("FAIL b2b_second_word: got %h expected 35", o);
                    end
                end
            end
            if (k == 8) begin
                n_checks++;
                if (s !== 3'd1 || busy !== 1'b1 || o !== 8'hC8 || err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_no_gap_sof: got s=%0d busy=%b o=%h err=%b expected s=1 busy=1 o=c8 err=0",
                             s, busy, o, err);
                end
            end
        end
        n_checks++;
        if (pulses !== 2 || first_at !== 7 || second_at - first_at !== 8) begin
            n_fail++;
            $display("FAIL b2b_spacing: got pulses=%0d first=%0d second=%0d expected 2 at 7 and 15",
                     pulses, first_at, second_at);
        end
        beat(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_resync();
        logic [7:0]  w;
        int unsigned errs;
        w = 8'hA5;
        errs = 0;
        for (int k = 0; k < 4; k++) begin
            beat(1'b1, k == 0, 1'b1);
            if (err === 1'b1) errs++;
        end
        for (int k = 0; k < 8; k++) begin
            beat(1'b1, k == 0, w[k]);
            if (err === 1'b1) errs++;
            if (k == 0) begin
                n_checks++;
                if (err !== 1'b1 || s !== 3'd1 || busy !== 1'b1 || o !== 8'h35 || o_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL resync_beat: got err=%b s=%0d busy=%b o=%h ov=%b expected err=1 s=1 busy=1 o=35 ov=0",
                             err, s, busy, o, o_valid);
                end
            end else if (k < 7) begin
                n_checks++;
                if (o !== 8'h35) begin
                    n_fail++;
                    $display("FAIL resync_hold_o_%0d: got %h expected 35", k, o);
                end
            end
        end
        n_checks++;
        if (o !== 8'hA5 || o_valid !== 1'b1 || errs !== 1) begin
            n_fail++;
            $display("FAIL resync_done: got o=%h ov=%b errs=%0d expected o=a5 ov=1 errs=1",
                     o, o_valid, errs);
        end
        beat(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_and_async_reset();
        logic [7:0] w;
        for (int k = 0; k < 5; k++) begin
            beat(1'b1, 1'b0, 1'b1);
            n_checks++;
            if (s !== 3'd0 || busy !== 1'b0 || o_valid !== 1'b0 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL ignore_nosof_%0d: got s=%0d busy=%b ov=%b err=%b expected 0 0 0 0",
                         k, s, busy, o_valid, err);
            end
        end
        for (int k = 0; k < 3; k++) beat(1'b1, k == 0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (s !== 3'd0 || o !== 8'h00 || busy !== 1'b0 || o4 !== 4'h0) begin
            n_fail++;
            $display("FAIL async_reset: got s=%0d o=%h busy=%b o4=%h expected 0 00 0 0",
                     s, o, busy, o4);
        end
        din_valid = 1'b1; sof = 1'b1; din = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        din_valid = 1'b0; sof = 1'b0; din = 1'b0;
        n_checks++;
        if (s !== 3'd0 || o !== 8'h00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: got s=%0d o=%h busy=%b expected 0 00 0", s, o, busy);
        end
        rst_n = 1'b1;
        w = 8'h3C;
        for (int k = 0; k < 8; k++) beat(1'b1, k == 0, w[k]);
        n_checks++;
        if (o !== 8'h3C || o_valid !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_frame: got o=%h ov=%b err=%b expected o=3c ov=1 err=0",
                     o, o_valid, err);
        end
        beat(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_n4();
        logic [3:0] w;
        w = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (s4 !== 2'(k)) begin
                n_fail++;
                $display("FAIL n4_slot_%0d: got s=%0d expected %0d", k, s4, k);
            end
            beat4(1'b1, k == 0, w[k]);
        end
        n_checks++;
        if (o4 !== 4'hA || o_valid4 !== 1'b1 || s4 !== 2'd0 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL n4_done: got o=%h ov=%b s=%0d busy=%b expected o=a ov=1 s=0 busy=0",
                     o4, o_valid4, s4, busy4);
        end
        beat4(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (o_valid4 !== 1'b0 || o4 !== 4'hA) begin
            n_fail++;
            $display("FAIL n4_pulse_width: got ov=%b o=%h expected ov=0 o=a", o_valid4, o4);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_frame();
        test_gaps();
        test_back_to_back();
        test_resync();
        test_ignore_and_async_reset();
        test_n4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
